// File: rtl/box_pkg.sv
// Shared types and helpers for the per-frame bounding-box table (box_frame_ctrl).
package box_pkg;

  localparam int COORD_W = 16;

  typedef struct packed {
    logic [COORD_W-1:0] sx;
    logic [COORD_W-1:0] sy;
    logic [COORD_W-1:0] ex;
    logic [COORD_W-1:0] ey;
    logic [23:0]        color;
  } box_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_COMMIT,
    S_CLEAR
  } state_t;

  function automatic int coord_width(input int act);
    return $clog2(act);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Order the corners first so the clamp can never invert a box.
  function automatic box_t normalise_box(input box_t b, input int h_act, input int v_act);
    box_t               r;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_max;
    x_max = COORD_W'(h_act - 1);
    y_max = COORD_W'(v_act - 1);
    r = b;
    if (b.sx > b.ex) begin
      r.sx = b.ex;
      r.ex = b.sx;
    end
    if (b.sy > b.ey) begin
      r.sy = b.ey;
      r.ey = b.sy;
    end
    if (r.sx > x_max) r.sx = x_max;
    if (r.ex > x_max) r.ex = x_max;
    if (r.sy > y_max) r.sy = y_max;
    if (r.ey > y_max) r.ey = y_max;
    return r;
  endfunction

endpackage

// File: rtl/box_slot.sv
// One bounding-box slot: shadow copy written by detection, live copy seen by overlay.
// Ageing is compiled in only when BOX_FRAME_CTRL_TTL_EN is defined.
module box_slot
  import box_pkg::*;
#(
  parameter int TTL_FRAMES = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic wr_en,
  input  box_t wr_box,
  input  logic commit,
  input  logic clear,
  output box_t live_box,
  output logic live
);

  box_t shadow;

`ifdef BOX_FRAME_CTRL_TTL_EN
  logic [7:0] ttl;
  logic [7:0] ttl_dec;

  assign ttl_dec = (ttl != 8'd0) ? ttl - 8'd1 : 8'd0;

  // An expired slot is published as an all-zero box so overlay treats it as invalid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow   <= '0;
      live_box <= '0;
      ttl      <= '0;
      live     <= 1'b0;
    end else if (clear) begin
      shadow   <= '0;
      live_box <= '0;
      ttl      <= '0;
      live     <= 1'b0;
    end else if (commit) begin
      ttl      <= ttl_dec;
      live     <= (ttl_dec != 8'd0);
      live_box <= (ttl_dec != 8'd0) ? shadow : '0;
    end else if (wr_en) begin
      shadow <= wr_box;
      ttl    <= 8'(TTL_FRAMES);
    end
  end
`else
  logic written;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow   <= '0;
      live_box <= '0;
      written  <= 1'b0;
      live     <= 1'b0;
    end else if (clear) begin
      shadow   <= '0;
      live_box <= '0;
      written  <= 1'b0;
      live     <= 1'b0;
    end else if (commit) begin
      live_box <= shadow;
      live     <= written;
    end else if (wr_en) begin
      shadow  <= wr_box;
      written <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/box_frame_ctrl.sv
// Per-frame bounding-box table: shadow writes, vsync-aligned commit, clear sweep.
// Optional box ageing is enabled by defining BOX_FRAME_CTRL_TTL_EN.
module box_frame_ctrl
  import box_pkg::*;
#(
  parameter  int N_BOX      = 4,
  parameter  int H_ACT      = 1280,
  parameter  int V_ACT      = 720,
  parameter  int TTL_FRAMES = 8,
  localparam int HW         = coord_width(H_ACT),
  localparam int VW         = coord_width(V_ACT),
  localparam int IW         = idx_width(N_BOX)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_vsync,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [IW-1:0]     wr_idx,
  input  logic [HW-1:0]     wr_sx,
  input  logic [HW-1:0]     wr_ex,
  input  logic [VW-1:0]     wr_sy,
  input  logic [VW-1:0]     wr_ey,
  input  logic [23:0]       wr_color,
  input  logic              clr_req,
  output logic [N_BOX*HW-1:0] start_xs,
  output logic [N_BOX*HW-1:0] end_xs,
  output logic [N_BOX*VW-1:0] start_ys,
  output logic [N_BOX*VW-1:0] end_ys,
  output logic [N_BOX*24-1:0] colors,
  output logic [N_BOX-1:0]  box_live,
  output logic              busy
);

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] cnt;
  logic          vs_d;
  logic          vs_rise;
  logic          wr_accept;
  box_t          wr_box;
  box_t          live_box [N_BOX];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_RUN;
      cnt     <= '0;
      vs_d    <= 1'b0;
      vs_rise <= 1'b0;
    end else begin
      state   <= state_nx;
      vs_d    <= i_vsync;
      vs_rise <= i_vsync & ~vs_d;
      cnt     <= (state == S_CLEAR) ? cnt + 1'b1 : '0;
    end
  end

  // A clear request outranks a frame edge; edges seen while clearing are dropped.
  always_comb begin
    state_nx = state;
    case (state)
      S_RUN: begin
        if (clr_req)      state_nx = S_CLEAR;
        else if (vs_rise) state_nx = S_COMMIT;
      end
      S_COMMIT: state_nx = S_RUN;
      S_CLEAR: begin
        if (cnt == IW'(N_BOX - 1)) state_nx = S_RUN;
      end
      default: state_nx = S_RUN;
    endcase
  end

  assign wr_ready  = rstn & (state == S_RUN);
  assign busy      = (state != S_RUN);
  assign wr_accept = wr_valid & wr_ready;

  always_comb begin
    wr_box = normalise_box('{sx:    COORD_W'(wr_sx),
                             sy:    COORD_W'(wr_sy),
                             ex:    COORD_W'(wr_ex),
                             ey:    COORD_W'(wr_ey),
                             color: wr_color}, H_ACT, V_ACT);
  end

  for (genvar i = 0; i < N_BOX; i++) begin : g_slot
    box_slot #(
      .TTL_FRAMES(TTL_FRAMES)
    ) u_slot (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en    (wr_accept && (wr_idx == IW'(i))),
      .wr_box   (wr_box),
      .commit   (state == S_COMMIT),
      .clear    ((state == S_CLEAR) && (cnt == IW'(i))),
      .live_box (live_box[i]),
      .live     (box_live[i])
    );

    // Clamped coordinates always fit the narrow port fields.
    assign start_xs[i*HW +: HW] = HW'(live_box[i].sx);
    assign end_xs[i*HW +: HW]   = HW'(live_box[i].ex);
    assign start_ys[i*VW +: VW] = VW'(live_box[i].sy);
    assign end_ys[i*VW +: VW]   = VW'(live_box[i].ey);
    assign colors[i*24 +: 24]   = live_box[i].color;
  end

endmodule

// File: tb/tb_box_frame_ctrl.sv
// Directed bench for box_frame_ctrl with a scoreboard of expected live tables.
// Expectations follow BOX_FRAME_CTRL_TTL_EN when it is defined.
module tb_box_frame_ctrl;

  localparam int N   = 4;
  localparam int H   = 1280;
  localparam int V   = 720;
  localparam int HW  = 11;
  localparam int VW  = 10;
  localparam int TTL = 2;

  logic            clk;
  logic            rstn;
  logic            i_vsync;
  logic            wr_valid;
  logic            wr_ready;
  logic [1:0]      wr_idx;
  logic [HW-1:0]   wr_sx;
  logic [HW-1:0]   wr_ex;
  logic [VW-1:0]   wr_sy;
  logic [VW-1:0]   wr_ey;
  logic [23:0]     wr_color;
  logic            clr_req;
  logic [N*HW-1:0] start_xs;
  logic [N*HW-1:0] end_xs;
  logic [N*VW-1:0] start_ys;
  logic [N*VW-1:0] end_ys;
  logic [N*24-1:0] colors;
  logic [N-1:0]    box_live;
  logic            busy;

  box_frame_ctrl #(
    .N_BOX(N), .H_ACT(H), .V_ACT(V), .TTL_FRAMES(TTL)
  ) dut (
    .clk(clk), .rstn(rstn), .i_vsync(i_vsync),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_sx(wr_sx), .wr_ex(wr_ex), .wr_sy(wr_sy), .wr_ey(wr_ey),
    .wr_color(wr_color), .clr_req(clr_req),
    .start_xs(start_xs), .end_xs(end_xs), .start_ys(start_ys), .end_ys(end_ys),
    .colors(colors), .box_live(box_live), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [HW-1:0] sx;
    logic [HW-1:0] ex;
    logic [VW-1:0] sy;
    logic [VW-1:0] ey;
    logic [23:0]   c;
  } tb_box_t;

  typedef struct packed {
    logic [N*HW-1:0] sxs;
    logic [N*HW-1:0] exs;
    logic [N*VW-1:0] sys;
    logic [N*VW-1:0] eys;
    logic [N*24-1:0] cols;
    logic [N-1:0]    lv;
  } snap_t;

  snap_t   exp_q[$];
  tb_box_t m_sh[N];
  tb_box_t m_lv[N];
  logic    m_wr[N];
  logic    m_lvf[N];
  int      m_ttl[N];
  int      n_assert = 0;
  int      n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tb_box_t norm(input int sx, input int sy, input int ex, input int ey,
                                   input logic [23:0] c);
    tb_box_t r;
    int lo_x, hi_x, lo_y, hi_y;
    lo_x = (sx < ex) ? sx : ex;
    hi_x = (sx < ex) ? ex : sx;
    lo_y = (sy < ey) ? sy : ey;
    hi_y = (sy < ey) ? ey : sy;
    if (lo_x > H - 1) lo_x = H - 1;
    if (hi_x > H - 1) hi_x = H - 1;
    if (lo_y > V - 1) lo_y = V - 1;
    if (hi_y > V - 1) hi_y = V - 1;
    r.sx = HW'(lo_x);
    r.ex = HW'(hi_x);
    r.sy = VW'(lo_y);
    r.ey = VW'(hi_y);
    r.c  = c;
    return r;
  endfunction

  function automatic snap_t modelSnap();
    snap_t s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s.sxs[i*HW +: HW] = m_lv[i].sx;
      s.exs[i*HW +: HW] = m_lv[i].ex;
      s.sys[i*VW +: VW] = m_lv[i].sy;
      s.eys[i*VW +: VW] = m_lv[i].ey;
      s.cols[i*24 +: 24] = m_lv[i].c;
      s.lv[i] = m_lvf[i];
    end
    return s;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_sh[i] = '0; m_lv[i] = '0; m_wr[i] = 1'b0; m_lvf[i] = 1'b0; m_ttl[i] = 0;
    end
  endtask

  task automatic modelWrite(input int slot, input int sx, input int sy, input int ex,
                            input int ey, input logic [23:0] c);
    m_sh[slot]  = norm(sx, sy, ex, ey, c);
    m_wr[slot]  = 1'b1;
    m_ttl[slot] = TTL;
  endtask

  task automatic modelCommit();
    for (int i = 0; i < N; i++) begin
`ifdef BOX_FRAME_CTRL_TTL_EN
      if (m_ttl[i] > 0) m_ttl[i]--;
      m_lvf[i] = (m_ttl[i] != 0);
      m_lv[i]  = m_lvf[i] ? m_sh[i] : '0;
`else
      m_lv[i]  = m_sh[i];
      m_lvf[i] = m_wr[i];
`endif
    end
    exp_q.push_back(modelSnap());
  endtask

  task automatic checkOutput(input string tag);
    snap_t e;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("[TB] FAIL %s scoreboard empty: observed=none expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    checkValue($sformatf("%s.start_xs", tag), start_xs, e.sxs);
    checkValue($sformatf("%s.end_xs", tag),   end_xs,   e.exs);
    checkValue($sformatf("%s.start_ys", tag), start_ys, e.sys);
    checkValue($sformatf("%s.end_ys", tag),   end_ys,   e.eys);
    checkValue($sformatf("%s.colors", tag),   colors,   e.cols);
    checkValue($sformatf("%s.box_live", tag), box_live, e.lv);
  endtask

  task automatic driveWrite(input int slot, input int sx, input int sy, input int ex,
                            input int ey, input logic [23:0] c);
    wr_valid = 1'b1;
    wr_idx   = 2'(slot);
    wr_sx    = HW'(sx);
    wr_ex    = HW'(ex);
    wr_sy    = VW'(sy);
    wr_ey    = VW'(ey);
    wr_color = c;
    for (int k = 0; k < 10 && !wr_ready; k++) tick();
    checkValue("write_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    modelWrite(slot, sx, sy, ex, ey, c);
  endtask

  // One vsync rising edge, then compare the live table one cycle after the commit cycle.
  task automatic applyStimulus(input string tag);
    i_vsync = 1'b1;
    modelCommit();
    tick();
    i_vsync = 1'b0;
    for (int k = 0; k < 8 && !busy; k++) tick();
    checkValue($sformatf("%s.commit_seen", tag), busy, 1);
    tick();
    checkOutput(tag);
  endtask

  initial begin
    int lows;
    int busy_cnt;
    modelReset();
    rstn = 1'b0; i_vsync = 1'b0; wr_valid = 1'b0; wr_idx = '0; wr_sx = '0; wr_ex = '0;
    wr_sy = '0; wr_ey = '0; wr_color = '0; clr_req = 1'b0;
    repeat (3) tick();
    checkValue("reset.wr_ready", wr_ready, 0);
    checkValue("reset.busy", busy, 0);
    exp_q.push_back(modelSnap());
    checkOutput("reset");
    rstn = 1'b1;
    #1;
    checkValue("post_reset.wr_ready", wr_ready, 1);

    $display("[TB] basic write and commit");
    driveWrite(0, 100, 50, 200, 150, 24'hFF0000);
    applyStimulus("t1");
    checkValue("t1.start_x0", start_xs[HW-1:0], 100);
    checkValue("t1.end_y0", end_ys[VW-1:0], 150);
    checkValue("t1.box_live", box_live, 4'b0001);

    $display("[TB] normalisation and last write wins");
    driveWrite(1, 300, 20, 100, 800, 24'h00FF00);
    driveWrite(2, 5, 6, 7, 8, 24'h123456);
    driveWrite(2, 2047, 1023, 40, 30, 24'hABCDEF);
    applyStimulus("t2");
    checkValue("t2.start_x1", start_xs[2*HW-1:HW], 100);
    checkValue("t2.end_x1", end_xs[2*HW-1:HW], 300);
    checkValue("t2.end_y1", end_ys[2*VW-1:VW], 719);
    checkValue("t2.color2", colors[71:48], 24'hABCDEF);

    $display("[TB] ageing or persistence over 10 frames");
    driveWrite(3, 10, 10, 20, 20, 24'h0000FF);
    for (int f = 0; f < 10; f++) applyStimulus($sformatf("t3.f%0d", f));
`ifdef BOX_FRAME_CTRL_TTL_EN
    checkValue("t3.live3", box_live[3], 0);
`else
    checkValue("t3.live3", box_live[3], 1);
`endif

    $display("[TB] write held through vsync edge");
    wr_valid = 1'b1; wr_idx = 2'd1; wr_sx = 11'd400; wr_ex = 11'd500;
    wr_sy = 10'd60; wr_ey = 10'd70; wr_color = 24'h00AA55;
    i_vsync = 1'b1;
    modelWrite(1, 400, 60, 500, 70, 24'h00AA55);
    modelCommit();
    lows = 0;
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (!wr_ready) lows++;
      if (busy) busy_cnt++;
    end
    i_vsync = 1'b0;
    wr_valid = 1'b0;
    m_ttl[1] = TTL;
    checkValue("t4.ready_low_cycles", lows, 1);
    checkValue("t4.commits", busy_cnt, 1);
    checkOutput("t4");

    $display("[TB] clear wins over vsync edge");
    driveWrite(2, 1, 2, 3, 4, 24'h777777);
    i_vsync = 1'b1;
    tick();
    clr_req = 1'b1;
    i_vsync = 1'b0;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy) busy_cnt++;
      tick();
    end
    checkValue("t5.busy_cycles", busy_cnt, 4);
    modelReset();
    exp_q.push_back(modelSnap());
    checkOutput("t5.cleared");
    applyStimulus("t5.after");

    $display("[TB] reset during clear");
    driveWrite(3, 600, 300, 700, 400, 24'h55AA00);
    applyStimulus("t6.pre");
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    rstn = 1'b0;
    #1;
    modelReset();
    exp_q.push_back(modelSnap());
    checkOutput("t6.in_reset");
    checkValue("t6.busy", busy, 0);
    checkValue("t6.wr_ready", wr_ready, 0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    checkValue("t6.run_busy", busy, 0);
    checkValue("t6.run_ready", wr_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
